// File: rtl/lsu_pkg.sv
// Shared widths and FSM state encoding for the load/store unit.
package lsu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  // VERIFY is only reachable when LSU_READBACK_EN is defined
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    VERIFY = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory interface: one load/store per handshake,
// registered Address/WriteData/writeEnable, one-cycle response pulse.
// Optional feature macro: LSU_READBACK_EN adds a VERIFY readback after each
// store and the rsp_err port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = lsu_pkg::ADDR_W,
  parameter int unsigned DATA_W = lsu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef LSU_READBACK_EN
  output logic              rsp_err,
`endif
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              writeEnable,
  input  logic [DATA_W-1:0] Data
);

  lsu_state_t state;
  lsu_state_t state_next;
  logic       accept;

  // Ready is gated by reset so a request coinciding with reset is never taken
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = req_write ? WRITE : READ;
      READ:    state_next = RESP;
`ifdef LSU_READBACK_EN
      WRITE:   state_next = VERIFY;
`else
      WRITE:   state_next = RESP;
`endif
      VERIFY:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory-port and response registers, decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      Address     <= '0;
      WriteData   <= '0;
      writeEnable <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef LSU_READBACK_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      writeEnable <= (state_next == WRITE);
      rsp_valid   <= (state_next == RESP);
      if (accept) begin
        Address <= req_addr;
        if (req_write) WriteData <= req_wdata;
      end
      if (state == READ) rsp_rdata <= Data;
`ifdef LSU_READBACK_EN
      if (state == VERIFY) begin
        rsp_rdata <= Data;
        rsp_err   <= (Data != WriteData);
      end
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 256-byte memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_READBACK_EN
  localparam int ST_LAT = 3;
`else
  localparam int ST_LAT = 2;
`endif

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
`ifdef LSU_READBACK_EN
  logic       rsp_err;
`endif
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic       writeEnable;
  logic [7:0] Data;

  logic [7:0] mem [256];
  logic       stuck;
  int         pass_cnt;
  int         total_cnt;

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
`ifdef LSU_READBACK_EN
    .rsp_err     (rsp_err),
`endif
    .Address     (Address),
    .WriteData   (WriteData),
    .writeEnable (writeEnable),
    .Data        (Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read with optional bit0 stuck-at-0, write at edge
  assign Data = mem[Address] & (stuck ? 8'hFE : 8'hFF);
  always @(posedge clk) if (writeEnable) mem[Address] <= WriteData;

  // Issue one request and observe it up to its response (lat = -1 on timeout)
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output int we_cnt,
                       output logic [7:0] we_addr, output logic [7:0] we_data,
                       output logic busy_ready, output logic err);
    int wait_cnt;
    lat = -1; rd = 8'h00; we_cnt = 0; we_addr = 8'h00; we_data = 8'h00;
    busy_ready = 1'b0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (writeEnable) begin
        we_cnt++;
        we_addr = Address;
        we_data = WriteData;
      end
      if (req_ready) busy_ready = 1'b1;
      if (rsp_valid) begin
        lat = k;
        rd  = rsp_rdata;
`ifdef LSU_READBACK_EN
        err = rsp_err;
`endif
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else pass_cnt++;
    total_cnt++;
    if ({Address, WriteData, rsp_rdata} !== 24'h0)
      $display("FAIL reset_regs: got %h/%h/%h want 00/00/00", Address, WriteData, rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({writeEnable, rsp_valid} !== 2'b00)
      $display("FAIL reset_ctl: got we=%b rv=%b want 0/0", writeEnable, rsp_valid);
    else pass_cnt++;
    // Request presented while reset is high must not be accepted
    req_valid = 1'b1; req_addr = 8'h07;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", req_ready); else pass_cnt++;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total_cnt++;
    if (seen !== 0 || Address !== 8'h00)
      $display("FAIL reset_req_ignored: rsp_cnt=%0d addr=%h want 0/00", seen, Address);
    else pass_cnt++;
  endtask

  task automatic test_load();
    int lat, wec; logic [7:0] rd, wa, wd; logic br, er;
    issue(1'b0, 8'h01, 8'h00, lat, rd, wec, wa, wd, br, er);
    total_cnt++;
    if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== 8'h00) $display("FAIL load_data: got %h want 00", rd); else pass_cnt++;
    total_cnt++;
    if (Address !== 8'h01) $display("FAIL load_addr: got %h want 01", Address); else pass_cnt++;
    total_cnt++;
    if (wec !== 0 || br !== 1'b0)
      $display("FAIL load_we_ready: we_cycles=%0d busy_ready=%b want 0/0", wec, br);
    else pass_cnt++;
  endtask

  task automatic test_store();
    int lat, wec; logic [7:0] rd, wa, wd; logic br, er;
    logic [7:0] exp_rd;
`ifdef LSU_READBACK_EN
    exp_rd = 8'h1F;
`else
    exp_rd = 8'h00;
`endif
    issue(1'b1, 8'h02, 8'h1F, lat, rd, wec, wa, wd, br, er);
    total_cnt++;
    if (lat !== ST_LAT) $display("FAIL store_latency: got %0d want %0d", lat, ST_LAT); else pass_cnt++;
    total_cnt++;
    if (wec !== 1 || wa !== 8'h02 || wd !== 8'h1F)
      $display("FAIL store_we: cycles=%0d addr=%h data=%h want 1/02/1F", wec, wa, wd);
    else pass_cnt++;
    total_cnt++;
    if (rd !== exp_rd) $display("FAIL store_rdata: got %h want %h", rd, exp_rd); else pass_cnt++;
    issue(1'b0, 8'h02, 8'h00, lat, rd, wec, wa, wd, br, er);
    total_cnt++;
    if (lat !== 2 || rd !== 8'h1F)
      $display("FAIL load_after_store: lat=%0d data=%h want 2/1F", lat, rd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ac[2]; int rc[2]; logic [7:0] rdv[2];
    int an, rn, low_cnt;
    ac = '{-100, -100}; rc = '{-50, -50}; rdv = '{8'hXX, 8'hXX};
    an = 0; rn = 0; low_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h02;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (rsp_valid && rn < 2) begin
        rc[rn] = cyc; rdv[rn] = rsp_rdata; rn++;
      end
      if (an == 1 && !req_ready) low_cnt++;
      if (req_ready && req_valid && an < 2) begin
        ac[an] = cyc; an++;
      end
      @(negedge clk);
      if (an == 1) req_addr = 8'h01;
      if (an == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    total_cnt++;
    if (ac[1] - ac[0] !== 3) $display("FAIL b2b_spacing: got %0d want 3", ac[1] - ac[0]); else pass_cnt++;
    total_cnt++;
    if (low_cnt !== 2) $display("FAIL b2b_ready_low: got %0d want 2", low_cnt); else pass_cnt++;
    total_cnt++;
    if (rc[0] - ac[0] !== 2 || rc[1] - ac[1] !== 2)
      $display("FAIL b2b_latency: got %0d/%0d want 2/2", rc[0] - ac[0], rc[1] - ac[1]);
    else pass_cnt++;
    total_cnt++;
    if (rdv[0] !== 8'h1F || rdv[1] !== 8'h00)
      $display("FAIL b2b_data: got %h/%h want 1F/00", rdv[0], rdv[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_read();
    int seen, wait_cnt, lat, wec; logic [7:0] rd, wa, wd; logic br, er;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h02;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL rst_read_ready: got %b want 0", req_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({Address, WriteData, rsp_rdata, writeEnable, rsp_valid, req_ready} !== 27'h0)
      $display("FAIL rst_read_outputs: addr=%h wd=%h rd=%h we=%b rv=%b rdy=%b want all 0",
               Address, WriteData, rsp_rdata, writeEnable, rsp_valid, req_ready);
    else pass_cnt++;
    reset = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_read_no_rsp: got %0d pulses want 0", seen); else pass_cnt++;
    issue(1'b0, 8'h02, 8'h00, lat, rd, wec, wa, wd, br, er);
    total_cnt++;
    if (lat !== 2 || rd !== 8'h1F)
      $display("FAIL rst_read_recover: lat=%0d data=%h want 2/1F", lat, rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_write();
    int seen, wait_cnt, lat, wec; logic [7:0] rd, wa, wd; logic br, er;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h55;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    @(negedge clk);
    req_valid = 1'b0;
    total_cnt++;
    if (writeEnable !== 1'b1) $display("FAIL rst_write_we: got %b want 1", writeEnable); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_write_no_rsp: got %0d pulses want 0", seen); else pass_cnt++;
    issue(1'b0, 8'h10, 8'h00, lat, rd, wec, wa, wd, br, er);
    total_cnt++;
    if (lat !== 2 || rd !== 8'h55)
      $display("FAIL rst_write_committed: lat=%0d data=%h want 2/55", lat, rd);
    else pass_cnt++;
  endtask

`ifdef LSU_READBACK_EN
  task automatic test_readback();
    int lat, wec; logic [7:0] rd, wa, wd; logic br, er;
    stuck = 1'b1;
    issue(1'b1, 8'h03, 8'hA5, lat, rd, wec, wa, wd, br, er);
    total_cnt++;
    if (lat !== 3 || wec !== 1)
      $display("FAIL readback_timing: lat=%0d we_cycles=%0d want 3/1", lat, wec);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 8'hA4 || er !== 1'b1)
      $display("FAIL readback_fault: data=%h err=%b want A4/1", rd, er);
    else pass_cnt++;
    stuck = 1'b0;
    issue(1'b1, 8'h03, 8'hA5, lat, rd, wec, wa, wd, br, er);
    total_cnt++;
    if (lat !== 3 || rd !== 8'hA5 || er !== 1'b0)
      $display("FAIL readback_clean: lat=%0d data=%h err=%b want 3/A5/0", lat, rd, er);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    stuck = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_read();
    test_reset_write();
`ifdef LSU_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the 8-bit CPU's data-memory interface.
- Accepts single load/store requests from the core datapath over a valid/ready handshake.
- Drives the Data_Memory port set (Address, WriteData, writeEnable) and samples its combinational Data output.
- Returns a one-cycle response pulse carrying the load data.
- Sits between the execute stage and Data_Memory; it is the only agent driving the memory.

## Interface
- ADDR_W, 8, address width; must match Data_Memory.
- DATA_W, 8, data width; must match Data_Memory.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE with reset low.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data (ignored for loads).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load data; valid while rsp_valid is high, held afterwards.
- rsp_err  out  1  readback mismatch; only present with LSU_READBACK_EN.
- Address  out  ADDR_W  to memory, registered.
- WriteData  out  DATA_W  to memory, registered.
- writeEnable  out  1  to memory, registered.
- Data  in  DATA_W  from memory, combinational read of Address.

## Operation
- FSM states: IDLE, READ, WRITE, VERIFY (macro only), RESP.
- Accept: req_valid && req_ready at an edge.
  - Latch req_addr into Address.
  - For a store, also latch req_wdata into WriteData.
  - Load goes to READ; store goes to WRITE.
- READ: writeEnable=0. At the end of the cycle, capture Data into rsp_rdata, then go to RESP.
- WRITE: writeEnable=1 for exactly this one cycle; memory commits at the closing edge.
  - Without macro: go to RESP.
  - With macro: go to VERIFY.
- VERIFY: writeEnable=0 with Address unchanged. Capture Data into rsp_rdata, set rsp_err = (Data != WriteData), go to RESP.
- RESP: rsp_valid=1 and req_ready=0, then go to IDLE.
- IDLE: Address and WriteData hold their last values. writeEnable is 0.
- rsp_rdata is left unchanged by a store unless the macro is on.
- req_valid is ignored outside IDLE. The core must hold the request until it is accepted; no request is buffered.
- Address and data are unsigned and pass straight through, with no arithmetic or wrap handling. Address 0xFF is legal.

## Timing
- Reset values:
  - state = IDLE.
  - Address, WriteData, rsp_rdata = 0.
  - writeEnable, rsp_valid, rsp_err = 0.
  - req_ready = 0 while reset is high.
- Accept at edge N:
  - Load: READ during cycle N+1, rsp_valid during N+2, req_ready high again at N+3. Latency 2, throughput one per 3 cycles.
  - Store, macro off: WRITE during N+1, rsp_valid during N+2.
  - Store, macro on: WRITE N+1, VERIFY N+2, rsp_valid N+3.
- If req_valid is held high continuously, the next accept occurs exactly at the first IDLE edge (load: N+3).
- Reset asserted mid-operation:
  - The FSM returns to IDLE at that edge and no rsp_valid is produced for the aborted request.
  - If reset is sampled during a WRITE cycle, writeEnable was already high, so memory commits that store. The core must treat the store as possibly done.
- Reset and req_valid in the same cycle: the request is not accepted.

## Configuration
- LSU_READBACK_EN defined: adds the VERIFY state and the rsp_err port. Stores take one extra cycle and return the readback value in rsp_rdata.
- LSU_READBACK_EN undefined:
  - No VERIFY state and no rsp_err port.
  - Store latency equals load latency.
  - rsp_rdata is untouched by stores.

## Structure
- Shared package lsu_pkg holds:
  - ADDR_W and DATA_W defaults.
  - typedef enum lsu_state_t {IDLE, READ, WRITE, VERIFY, RESP}; VERIFY is always declared, even when unused.
- Single module with no sub-module. The FSM and output registers are small enough to live together.

## Test plan
- Reset, then load 0x01 → rsp_valid 2 cycles after accept, rsp_rdata=0x00, Address=0x01, writeEnable never high.
- Store 0x1F to 0x02, then load 0x02 → writeEnable high exactly one cycle with Address=0x02 and WriteData=0x1F; the load returns 0x1F.
- req_valid held high with load 0x02 then load 0x01 back-to-back → accepts spaced by exactly 3 cycles; req_ready low in READ and RESP; responses 0x1F then 0x00.
- Reset asserted during the READ cycle of load 0x02 → no rsp_valid; req_ready=0 during reset; all outputs at reset values; next load 0x02 completes normally.
- Reset asserted during the WRITE cycle of store 0x55 to 0x10 → no rsp_valid; a subsequent load 0x10 returns 0x55.
- Macro on: store 0xA5 to 0x03 with the memory model forcing bit0 stuck-at-0 → VERIFY cycle present, rsp_valid 3 cycles after accept, rsp_rdata=0xA4, rsp_err=1. Fault-free repeat → rsp_err=0.
